climit_cond: RTL and testbench

Current-limit conditioner that sits directly upstream of the pwm8 channel and drives its currentlimit input. It takes the raw asynchronous over-current comparator signal and synchronises, blanks and filters it. It latches a per-period limit that releases at each PWM period start. Repeated limited periods escalate to a latched fault, which the host uses to drop enablepwm.

---
 rtl/climit_cond_if.sv | 33 +++
 rtl/climit_cond.sv | 185 ++++++++++++++++++
 tb/tb_climit_cond.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/climit_cond_if.sv
// ============================================================================
// Module   : climit_cond_if
// Brief    : Bundle between the PWM/host side and the current-limit
//            conditioner: PWM timing, raw comparator, fault clear, and the
//            conditioned limit/fault/status outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface climit_cond_if;
  logic       pwmcntce;
  logic [7:0] pwmcount;
  logic       climit_raw;
  logic       faultclr;
  logic       currentlimit;
  logic       faultlatch;
  logic       blanking;
  logic [7:0] limitcount;

  // Host / PWM side: drives timing and comparator, observes results
  modport master (
    output pwmcntce, pwmcount, climit_raw, faultclr,
    input  currentlimit, faultlatch, blanking, limitcount
  );

  // Conditioner side
  modport slave (
    input  pwmcntce, pwmcount, climit_raw, faultclr,
    output currentlimit, faultlatch, blanking, limitcount
  );
endinterface

`default_nettype wire

// File: rtl/climit_cond.sv
// ============================================================================
// Module   : climit_cond
// Brief    : Over-current conditioner for pwm8. Synchronises the raw
//            comparator, ignores it during a blanking window after each PWM
//            period start, filters it over FILT_LEN clocks, latches a limit
//            for the rest of the period and escalates repeated limited
//            periods to a latched fault.
//            Optional macro CLIMIT_AUTORETRY_EN: fault auto-clears after
//            RETRY_PERIODS period starts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module climit_cond #(
  parameter int SYNC_STAGES   = 2,
  parameter int BLANK_TICKS   = 8,
  parameter int FILT_LEN      = 3,
  parameter int FAULT_CYCLES  = 4,
  parameter int RETRY_PERIODS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  climit_cond_if.slave bus
);

  localparam logic [7:0] C_BLANK_LOAD   = 8'(BLANK_TICKS);
  localparam logic [3:0] C_FILT_LAST    = 4'(FILT_LEN - 1);
  localparam logic [3:0] C_FAULT_CYCLES = 4'(FAULT_CYCLES);

  // Elaboration-time parameter range checks
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
    $error("climit_cond: SYNC_STAGES out of range 2..4");
  end
  if (BLANK_TICKS < 0 || BLANK_TICKS > 255) begin : g_chk_blank
    $error("climit_cond: BLANK_TICKS out of range 0..255");
  end
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_chk_filt
    $error("climit_cond: FILT_LEN out of range 1..15");
  end
  if (FAULT_CYCLES < 1 || FAULT_CYCLES > 15) begin : g_chk_fault
    $error("climit_cond: FAULT_CYCLES out of range 1..15");
  end
  if (RETRY_PERIODS < 1 || RETRY_PERIODS > 255) begin : g_chk_retry
    $error("climit_cond: RETRY_PERIODS out of range 1..255");
  end

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LIMITED = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             blank_q;
  logic [3:0]             filt_q;
  state_t                 state_q, state_d;
  logic [3:0]             consec_q, consec_d;
  logic [7:0]             limcnt_q, limcnt_d;
`ifdef CLIMIT_AUTORETRY_EN
  localparam logic [7:0] C_RETRY_LAST = 8'(RETRY_PERIODS);
  logic [7:0]             retry_q, retry_d;
`endif

  logic w_ps;
  logic w_blanking;
  logic w_cond;
  logic w_detect;
  logic w_fault_entry;

  // Period start coincides with the edge where pwm8 drives its output high
  assign w_ps       = bus.pwmcntce && (bus.pwmcount == 8'hFF);
  assign w_blanking = (blank_q != 8'd0);
  assign w_cond     = sync_q[SYNC_STAGES-1] && !w_blanking;
  // A detection in the period-start cycle is dropped: the new period wins
  assign w_detect   = w_cond && (filt_q == C_FILT_LAST) && (state_q == S_RUN) && !w_ps;
  assign w_fault_entry = (state_q == S_LIMITED) && w_ps &&
                         ((consec_q + 4'd1) == C_FAULT_CYCLES);

  // Comparator synchroniser chain
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.climit_raw};
  end

  // Blanking window: reload on period start, count down on PWM ticks
  always_ff @(posedge clk) begin
    if (!reset_n)                   blank_q <= 8'd0;
    else if (w_ps)                  blank_q <= C_BLANK_LOAD;
    else if (bus.pwmcntce && w_blanking) blank_q <= blank_q - 8'd1;
  end

  // Consecutive-sample filter; saturates so a steady level re-detects at once
  always_ff @(posedge clk) begin
    if (!reset_n)                filt_q <= 4'd0;
    else if (state_q == S_FAULT) filt_q <= 4'd0;
    else if (w_cond) begin
      if (filt_q != C_FILT_LAST) filt_q <= filt_q + 4'd1;
    end
    else                         filt_q <= 4'd0;
  end

  // FSM and period counters state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_RUN;
      consec_q <= 4'd0;
      limcnt_q <= 8'd0;
`ifdef CLIMIT_AUTORETRY_EN
      retry_q  <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      limcnt_q <= limcnt_d;
`ifdef CLIMIT_AUTORETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // FSM next state: limit latch lives in LIMITED, escalation into FAULT
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    limcnt_d = limcnt_q;
`ifdef CLIMIT_AUTORETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      S_RUN: begin
        if (w_ps)          consec_d = 4'd0;
        else if (w_detect) state_d  = S_LIMITED;
        if (bus.faultclr) begin
          consec_d = 4'd0;
          limcnt_d = 8'd0;
        end
      end
      S_LIMITED: begin
        if (w_ps) begin
          consec_d = consec_q + 4'd1;
          if (limcnt_q != 8'hFF) limcnt_d = limcnt_q + 8'd1;
          state_d = w_fault_entry ? S_FAULT : S_RUN;
        end
        // Fault entry takes precedence over a coincident clear
        if (bus.faultclr && !w_fault_entry) begin
          consec_d = 4'd0;
          limcnt_d = 8'd0;
        end
      end
      S_FAULT: begin
`ifdef CLIMIT_AUTORETRY_EN
        if (w_ps) begin
          if ((retry_q + 8'd1) == C_RETRY_LAST) begin
            state_d  = S_RUN;
            consec_d = 4'd0;
            retry_d  = 8'd0;
          end else begin
            retry_d  = retry_q + 8'd1;
          end
        end
`endif
        if (bus.faultclr) begin
          state_d  = S_RUN;
          consec_d = 4'd0;
          limcnt_d = 8'd0;
`ifdef CLIMIT_AUTORETRY_EN
          retry_d  = 8'd0;
`endif
        end
      end
      default: begin
        state_d  = S_RUN;
        consec_d = 4'd0;
      end
    endcase
  end

  assign bus.currentlimit = (state_q == S_LIMITED) || (state_q == S_FAULT);
  assign bus.faultlatch   = (state_q == S_FAULT);
  assign bus.blanking     = w_blanking;
  assign bus.limitcount   = limcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_climit_cond.sv
// ============================================================================
// Module   : tb_climit_cond
// Brief    : Directed self-checking bench for climit_cond at default
//            parameters (RETRY_PERIODS=4 when CLIMIT_AUTORETRY_EN is set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_climit_cond;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  climit_cond_if bus ();

`ifdef CLIMIT_AUTORETRY_EN
  climit_cond #(.RETRY_PERIODS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );
`else
  climit_cond dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One period-start cycle
  task automatic ps();
    bus.pwmcntce = 1'b1;
    bus.pwmcount = 8'hFF;
    step(1);
    bus.pwmcntce = 1'b0;
    bus.pwmcount = 8'h00;
  endtask

  // One PWM counter tick that is not a period start
  task automatic tick();
    bus.pwmcntce = 1'b1;
    bus.pwmcount = 8'h40;
    step(1);
    bus.pwmcntce = 1'b0;
    bus.pwmcount = 8'h00;
    step(1);
  endtask

  task automatic pulse(input int n);
    bus.climit_raw = 1'b1;
    step(n);
    bus.climit_raw = 1'b0;
    step(4);
  endtask

  task automatic clr();
    bus.faultclr = 1'b1;
    step(1);
    bus.faultclr = 1'b0;
  endtask

  // Full period: ride out blanking, optionally trip a limit, then period start
  task automatic period(input logic lim);
    repeat (8) tick();
    if (lim) pulse(3);
    else     step(7);
    chk("period_limit", {31'd0, bus.currentlimit}, {31'd0, lim});
    ps();
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    bus.pwmcntce   = 1'b0;
    bus.pwmcount   = 8'h00;
    bus.climit_raw = 1'b1;
    bus.faultclr   = 1'b0;
    step(3);

    // Reset with comparator already high, then filter latency
    reset_n = 1'b1;
    step(1);
    chk("rst_currentlimit", {31'd0, bus.currentlimit}, 32'd0);
    chk("rst_faultlatch",   {31'd0, bus.faultlatch},   32'd0);
    chk("rst_blanking",     {31'd0, bus.blanking},     32'd0);
    chk("rst_limitcount",   {24'd0, bus.limitcount},   32'd0);
    step(3);
    chk("lat_edge4", {31'd0, bus.currentlimit}, 32'd0);
    step(1);
    chk("lat_edge5", {31'd0, bus.currentlimit}, 32'd1);

    // Reset mid-period drops the latch immediately
    bus.climit_raw = 1'b0;
    reset_n = 1'b0;
    step(1);
    chk("midrst_currentlimit", {31'd0, bus.currentlimit}, 32'd0);
    reset_n = 1'b1;

    // Comparator high inside the blanking window is ignored
    ps();
    chk("blank_start", {31'd0, bus.blanking}, 32'd1);
    bus.climit_raw = 1'b1;
    repeat (6) tick();
    chk("blank_tick6",    {31'd0, bus.blanking},     32'd1);
    chk("blank_cl_tick6", {31'd0, bus.currentlimit}, 32'd0);
    bus.climit_raw = 1'b0;
    tick();
    chk("blank_tick7", {31'd0, bus.blanking}, 32'd1);
    tick();
    chk("blank_tick8",  {31'd0, bus.blanking},     32'd0);
    chk("blank_cl_end", {31'd0, bus.currentlimit}, 32'd0);
    chk("blank_lc",     {24'd0, bus.limitcount},   32'd0);

    // Short pulses rejected, 3-clk pulse latches until next period start
    repeat (3) begin
      pulse(2);
      chk("short_pulse", {31'd0, bus.currentlimit}, 32'd0);
    end
    pulse(3);
    chk("long_pulse", {31'd0, bus.currentlimit}, 32'd1);
    step(5);
    chk("long_hold", {31'd0, bus.currentlimit}, 32'd1);
    ps();
    chk("ps_release", {31'd0, bus.currentlimit}, 32'd0);
    chk("ps_lc1",     {24'd0, bus.limitcount},   32'd1);

    // faultclr outside FAULT clears the count; four limited periods -> fault
    clr();
    chk("clr_lc", {24'd0, bus.limitcount}, 32'd0);
    period(1'b1);
    chk("f_lc1", {24'd0, bus.limitcount}, 32'd1);
    period(1'b1);
    chk("f_lc2", {24'd0, bus.limitcount}, 32'd2);
    period(1'b1);
    chk("f_lc3",  {24'd0, bus.limitcount}, 32'd3);
    chk("f_nof3", {31'd0, bus.faultlatch}, 32'd0);
    repeat (8) tick();
    pulse(3);
    chk("f_p4_limit", {31'd0, bus.currentlimit}, 32'd1);
    bus.faultclr = 1'b1;
    ps();
    bus.faultclr = 1'b0;
    chk("f_entry_wins", {31'd0, bus.faultlatch},   32'd1);
    chk("f_cl_forced",  {31'd0, bus.currentlimit}, 32'd1);
    pulse(3);
    chk("f_still", {31'd0, bus.faultlatch}, 32'd1);
    clr();
    chk("f_clr_fault", {31'd0, bus.faultlatch},   32'd0);
    chk("f_clr_lc",    {24'd0, bus.limitcount},   32'd0);
    chk("f_clr_cl",    {31'd0, bus.currentlimit}, 32'd0);

    // Clean period in the run resets the consecutive count
    period(1'b1);
    period(1'b1);
    period(1'b1);
    period(1'b0);
    chk("c_lc_p4",  {24'd0, bus.limitcount}, 32'd3);
    chk("c_nof_p4", {31'd0, bus.faultlatch}, 32'd0);
    period(1'b1);
    chk("c_lc_p5",  {24'd0, bus.limitcount}, 32'd4);
    chk("c_nof_p5", {31'd0, bus.faultlatch}, 32'd0);
    period(1'b1);
    period(1'b1);
    chk("c_nof_p7", {31'd0, bus.faultlatch}, 32'd0);
    period(1'b1);
    chk("c_fault_p8", {31'd0, bus.faultlatch}, 32'd1);
    chk("c_lc_p8",    {24'd0, bus.limitcount}, 32'd7);

`ifdef CLIMIT_AUTORETRY_EN
    // Auto-retry after four period starts, count kept
    repeat (3) ps();
    chk("retry_3", {31'd0, bus.faultlatch}, 32'd1);
    ps();
    chk("retry_4",    {31'd0, bus.faultlatch},   32'd0);
    chk("retry_cl",   {31'd0, bus.currentlimit}, 32'd0);
    chk("retry_lc",   {24'd0, bus.limitcount},   32'd7);
`else
    // Fault is sticky across many periods
    repeat (300) ps();
    chk("sticky_fault", {31'd0, bus.faultlatch},   32'd1);
    chk("sticky_cl",    {31'd0, bus.currentlimit}, 32'd1);
    chk("sticky_lc",    {24'd0, bus.limitcount},   32'd7);
`endif

    // Reset from here returns everything to zero
    reset_n = 1'b0;
    step(1);
    chk("end_rst_fault", {31'd0, bus.faultlatch},   32'd0);
    chk("end_rst_cl",    {31'd0, bus.currentlimit}, 32'd0);
    chk("end_rst_blank", {31'd0, bus.blanking},     32'd0);
    chk("end_rst_lc",    {24'd0, bus.limitcount},   32'd0);
    reset_n = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
